// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the E-stage control and the multiply/divide unit.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, op, A, B, flush, input busy, HI, LO);
  modport slave  (input start, op, A, B, flush, output busy, HI, LO);
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO registers; the result is computed at issue
// and held in a pending register until the programmed latency expires.
module mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_iter_if.slave md
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p_hi, p_lo;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, uq, ur, sq, sr, dq_u, dr_u;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               a_neg, b_neg, is_md;

  always_comb begin
    // Signed product from sign-extended operands; low 2*WIDTH bits are exact.
    prod_s = {{WIDTH{md.A[WIDTH-1]}}, md.A} * {{WIDTH{md.B[WIDTH-1]}}, md.B};
    prod_u = {{WIDTH{1'b0}}, md.A} * {{WIDTH{1'b0}}, md.B};

    // Sign-magnitude division; MIN_INT / -1 falls out naturally as MIN_INT rem 0.
    a_neg = md.A[WIDTH-1];
    b_neg = md.B[WIDTH-1];
    a_mag = a_neg ? (~md.A + 1'b1) : md.A;
    b_mag = b_neg ? (~md.B + 1'b1) : md.B;
    uq    = '0;
    ur    = '0;
    dq_u  = '0;
    dr_u  = '0;
    if (md.B != '0) begin
      uq   = a_mag / b_mag;
      ur   = a_mag % b_mag;
      dq_u = md.A / md.B;
      dr_u = md.A % md.B;
    end
    sq = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
    sr = a_neg ? (~ur + 1'b1) : ur;

    res_hi = '0;
    res_lo = '0;
    is_md  = 1'b1;
    case (md.op)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      3'd2: if (md.B == '0) begin
              res_hi = md.A;
              res_lo = '1;
            end else begin
              res_hi = sr;
              res_lo = sq;
            end
      3'd3: if (md.B == '0) begin
              res_hi = md.A;
              res_lo = '1;
            end else begin
              res_hi = dr_u;
              res_lo = dq_u;
            end
      default: is_md = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      md.busy <= 1'b0;
      md.HI   <= '0;
      md.LO   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
    end else if (md.flush) begin
      state   <= IDLE;
      cnt     <= '0;
      md.busy <= 1'b0;
      p_hi    <= '0;
      p_lo    <= '0;
    end else begin
      case (state)
        IDLE: if (md.start) begin
          if (is_md) begin
            p_hi    <= res_hi;
            p_lo    <= res_lo;
            cnt     <= md.op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            md.busy <= 1'b1;
            state   <= RUN;
          end else if (md.op == 3'd4) begin
            md.HI <= md.A;
          end else if (md.op == 3'd5) begin
            md.LO <= md.A;
          end
        end
        RUN: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          md.HI   <= p_hi;
          md.LO   <= p_lo;
          md.busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
